// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - opcode constants and sequencer state encoding
package cpu_sequencer_pkg;

    // Opcode field of the instruction register
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;

    // 4-bit opcodes shared with the decoder
    localparam logic [3:0] OP_SUB       = 4'd0;
    localparam logic [3:0] OP_ADD       = 4'd1;
    localparam logic [3:0] OP_AND       = 4'd2;
    localparam logic [3:0] OP_OR        = 4'd3;
    localparam logic [3:0] OP_XOR       = 4'd4;
    localparam logic [3:0] OP_SHL       = 4'd5;
    localparam logic [3:0] OP_SHR       = 4'd6;
    localparam logic [3:0] OP_LI        = 4'd7;
    localparam logic [3:0] OP_MOV       = 4'd8;
    localparam logic [3:0] OP_LOAD      = 4'd9;
    localparam logic [3:0] OP_STORE     = 4'd10;
    localparam logic [3:0] OP_COMPARE   = 4'd11;
    localparam logic [3:0] OP_CHECK_ADJ = 4'd12;
    localparam logic [3:0] OP_CHECK_MAP = 4'd13;
    localparam logic [3:0] OP_JMP       = 4'd14;
    localparam logic [3:0] OP_JNZ       = 4'd15;

    // Sequencer state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } seq_state_e;

    // Branches are the only instructions that leave the zero flag alone
    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JNZ);
    endfunction

endpackage

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control sequencer
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int          PC_W    = 6,
    parameter int unsigned PC_LAST = 63
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     ir,
    output logic            zf,
    input  logic            alu_zf,
    input  logic            dec_reg_we,
    input  logic            dec_mem_we,
    input  logic            dec_pc_we,
    input  logic            dec_sel2,
    input  logic [PC_W-1:0] dec_pc_in,
    output logic            reg_we,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic            busy,
    output logic            done,
    output logic [15:0]     instr_count
);

    localparam logic [PC_W-1:0] PC_LAST_V = PC_W'(PC_LAST);

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            zf_q, zf_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [3:0]      opcode;

    assign opcode = ir_q[OPCODE_MSB:OPCODE_LSB];

    // State and architectural registers; reset abandons any pending access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= 16'h0000;
            zf_q    <= 1'b0;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            zf_q    <= zf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and register updates for each pipeline step
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        zf_d    = zf_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (!is_branch(opcode)) begin
                    zf_d = alu_zf;
                end
                state_d = (dec_mem_we || dec_sel2) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                pc_d    = dec_pc_we ? dec_pc_in : pc_q + 1'b1;
                cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                state_d = ((pc_q == PC_LAST_V) && !dec_pc_we) ? ST_HALT : ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Requests and strobes decode straight from the state register so reset drops them at once
    always_comb begin
        imem_req = (state_q == ST_FETCH);
        dmem_req = (state_q == ST_MEM);
        dmem_we  = (state_q == ST_MEM) && dec_mem_we;
        reg_we   = (state_q == ST_WB) && dec_reg_we;
        busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);
        done     = (state_q == ST_HALT);
    end

    assign imem_addr   = pc_q;
    assign ir          = ir_q;
    assign zf          = zf_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic        zf;
    logic        alu_zf;
    logic        dec_reg_we;
    logic        dec_mem_we;
    logic        dec_pc_we;
    logic        dec_sel2;
    logic [5:0]  dec_pc_in;
    logic        reg_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        busy;
    logic        done;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] imem [64];

    // reference model state
    int          m_pc;
    logic        m_zf;
    int          m_cnt;
    logic [15:0] m_ir_prev;
    bit          m_halted;

    cpu_sequencer #(.PC_W(6), .PC_LAST(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .zf(zf), .alu_zf(alu_zf),
        .dec_reg_we(dec_reg_we), .dec_mem_we(dec_mem_we), .dec_pc_we(dec_pc_we),
        .dec_sel2(dec_sel2), .dec_pc_in(dec_pc_in),
        .reg_we(reg_we), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .busy(busy), .done(done), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // decoder stand-in: raw controls from the current instruction register
    logic [3:0] dec_op;
    always_comb begin
        dec_op     = ir[15:12];
        dec_reg_we = !(dec_op == OP_STORE || dec_op == OP_COMPARE || dec_op == OP_JMP || dec_op == OP_JNZ);
        dec_mem_we = (dec_op == OP_STORE);
        dec_sel2   = (dec_op == OP_LOAD);
        dec_pc_we  = (dec_op == OP_JMP) || (dec_op == OP_JNZ && zf);
        dec_pc_in  = ir[5:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_reg_we", 32'(reg_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ir", 32'(ir), 32'd0);
        chk("rst_zf", 32'(zf), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_pc = 0; m_zf = 1'b0; m_cnt = 0; m_ir_prev = 16'h0000; m_halted = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_pc = 0;
        m_halted = 1'b0;
    endtask

    // Execute one instruction at the model PC; called at a negedge with the DUT in FETCH
    task automatic exec_one(input int iwait, input int dwait, input logic alu, input bit abort_mem);
        logic [15:0] ins;
        logic [3:0]  op;
        logic        pcwe, is_mem, rw, halt;
        int          npc;
        ins = imem[m_pc];
        op  = ins[15:12];
        for (int w = 0; w <= iwait; w++) begin
            chk("fetch_req", 32'(imem_req), 32'd1);
            chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
            chk("ir_hold", 32'(ir), 32'(m_ir_prev));
            chk("fetch_busy", 32'(busy), 32'd1);
            imem_ack   = (w == iwait);
            imem_rdata = (w == iwait) ? ins : 16'($urandom);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        chk("dec_ir", 32'(ir), 32'(ins));
        chk("dec_imem_req", 32'(imem_req), 32'd0);
        chk("dec_reg_we", 32'(reg_we), 32'd0);
        chk("dec_zf", 32'(zf), 32'(m_zf));
        alu_zf = alu;
        @(negedge clk);
        chk("exec_reg_we", 32'(reg_we), 32'd0);
        chk("exec_dmem_req", 32'(dmem_req), 32'd0);
        pcwe = (op == OP_JMP) || (op == OP_JNZ && m_zf);
        if (op != OP_JMP && op != OP_JNZ) m_zf = alu;
        is_mem = (op == OP_LOAD) || (op == OP_STORE);
        @(negedge clk);
        if (is_mem) begin
            for (int d = 0; d <= dwait; d++) begin
                chk("mem_req", 32'(dmem_req), 32'd1);
                chk("mem_we", 32'(dmem_we), 32'(op == OP_STORE));
                chk("mem_reg_we", 32'(reg_we), 32'd0);
                if (abort_mem) return;
                dmem_ack = (d == dwait);
                @(negedge clk);
            end
            dmem_ack = 1'b0;
        end
        rw = !(op == OP_STORE || op == OP_COMPARE || op == OP_JMP || op == OP_JNZ);
        chk("wb_reg_we", 32'(reg_we), 32'(rw));
        chk("wb_dmem_req", 32'(dmem_req), 32'd0);
        chk("wb_zf", 32'(zf), 32'(m_zf));
        chk("wb_count", 32'(instr_count), 32'(m_cnt));
        npc  = pcwe ? int'(ins[5:0]) : (m_pc + 1) % 64;
        halt = (m_pc == 3) && !pcwe;
        m_cnt = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
        m_pc = npc;
        m_ir_prev = ins;
        @(negedge clk);
        chk("post_reg_we", 32'(reg_we), 32'd0);
        chk("post_count", 32'(instr_count), 32'(m_cnt));
        chk("post_done", 32'(done), 32'(halt));
        chk("post_busy", 32'(busy), 32'(!halt));
        if (halt) begin
            chk("halt_imem_req", 32'(imem_req), 32'd0);
            m_halted = 1'b1;
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input int tgt);
        logic [5:0] t;
        t = 6'(tgt);
        return {op, 6'd0, t};
    endfunction

    initial begin
        rst = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
        alu_zf = 1'b0; dmem_ack = 1'b0;
        m_pc = 0; m_zf = 1'b0; m_cnt = 0; m_ir_prev = 16'h0000; m_halted = 1'b0;
        for (int i = 0; i < 64; i++) imem[i] = mk(OP_ADD, 0);
        imem[0]  = mk(OP_LI, 5);
        imem[1]  = mk(OP_ADD, 0);
        imem[2]  = mk(OP_LOAD, 0);
        imem[3]  = mk(OP_JMP, 4);
        imem[4]  = mk(OP_STORE, 0);
        imem[5]  = mk(OP_COMPARE, 0);
        imem[6]  = mk(OP_JNZ, 10);
        imem[10] = mk(OP_COMPARE, 0);
        imem[11] = mk(OP_JNZ, 20);
        imem[12] = mk(OP_JMP, 63);
        imem[63] = mk(OP_ADD, 0);

        @(negedge clk);
        do_reset();
        do_start();
        exec_one(0, 0, 1'b0, 1'b0);   // LI at 0
        exec_one(3, 0, 1'b0, 1'b0);   // ADD at 1, fetch ack delayed
        exec_one(0, 1, 1'b1, 1'b0);   // LOAD at 2, two MEM cycles
        exec_one(0, 0, 1'b0, 1'b0);   // JMP at PC_LAST continues
        exec_one(1, 0, 1'b0, 1'b0);   // STORE at 4
        exec_one(0, 0, 1'b1, 1'b0);   // COMPARE sets zf
        exec_one(0, 0, 1'b0, 1'b0);   // JNZ taken to 10
        exec_one(0, 0, 1'b0, 1'b0);   // COMPARE clears zf
        exec_one(0, 0, 1'b1, 1'b0);   // JNZ not taken, zf untouched
        exec_one(0, 0, 1'b0, 1'b0);   // JMP to 63
        exec_one(0, 0, 1'b0, 1'b0);   // ADD at 63 wraps to 0
        imem[3] = mk(OP_ADD, 0);
        for (int k = 0; k < 4; k++) exec_one(0, 0, 1'b0, 1'b0);
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_count", 32'(instr_count), 32'd15);
        do_start();
        exec_one(0, 0, 1'b0, 1'b0);   // restart from 0, count kept
        chk("restart_count", 32'(instr_count), 32'd16);
        exec_one(0, 0, 1'b0, 1'b0);
        exec_one(0, 2, 1'b0, 1'b1);   // LOAD at 2, reset mid-MEM
        do_reset();
        do_start();
        exec_one(0, 0, 1'b0, 1'b0);
        chk("resume_count", 32'(instr_count), 32'd1);

        // randomized programs against the model
        for (int run = 0; run < 6; run++) begin
            for (int i = 0; i < 64; i++) begin
                logic [3:0] rop;
                rop = 4'($urandom_range(0, 15));
                if (rop == OP_JMP && $urandom_range(0, 1) == 0) rop = OP_ADD;
                imem[i] = {rop, 6'($urandom), 6'($urandom)};
            end
            do_reset();
            do_start();
            for (int k = 0; k < 30 && !m_halted; k++) begin
                exec_one($urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 16-bit four-color-solver core. It owns the program counter, instruction register and zero flag. It steps each instruction through fetch, decode, execute, memory and writeback, and gates the decoder's raw write-enables into one-cycle strobes. It sits between instruction/data memory handshakes and the combinational decoder/ALU/register-file datapath.

## Interface
- `PC_W`, default 6: PC width; matches the decoder `pc_in` width.
- `PC_LAST`, default 63: the core halts after executing the instruction at this address, unless that instruction takes a jump.
- `clk` input 1: the single clock.
- `rst` input 1: asynchronous reset, active-high.
- `start` input 1: level; sampled in IDLE and HALT; begins execution at PC 0.
- `imem_req` output 1: instruction fetch request.
- `imem_addr` output PC_W: fetch address, equal to the PC.
- `imem_ack` input 1: fetch data valid this cycle.
- `imem_rdata` input 16: fetched instruction.
- `ir` output 16: instruction register; drives decoder `op`.
- `zf` output 1: registered zero flag; drives decoder `zf`.
- `alu_zf` input 1: ALU zero result, combinational.
- `dec_reg_we`, `dec_mem_we`, `dec_pc_we`, `dec_sel2` input 1 each: raw decoder controls.
- `dec_pc_in` input PC_W: decoder jump target.
- `reg_we` output 1: register-file write strobe.
- `dmem_req` output 1: data memory request.
- `dmem_we` output 1: data memory write qualifier; valid while `dmem_req` is high.
- `dmem_ack` input 1: data access complete.
- `busy` output 1: high in every state except IDLE and HALT.
- `done` output 1: high in HALT.
- `instr_count` output 16: retired-instruction counter.

## Operation
- States:
  - IDLE: go to FETCH when `start` is high.
  - FETCH: hold `imem_req` high with `imem_addr` = PC. On `imem_ack`, load `ir` from `imem_rdata` and go to DECODE.
  - DECODE: one settling cycle for the decoder and register file. Then go to EXEC.
  - EXEC: for any opcode other than JMP/JNZ, load `zf` from `alu_zf`. If `dec_mem_we` or `dec_sel2` is set, go to MEM; otherwise go to WB.
  - MEM: hold `dmem_req` high, with `dmem_we` = `dec_mem_we`, until `dmem_ack`. Then go to WB.
  - WB:
    - `reg_we` is high for exactly this cycle when `dec_reg_we` is set.
    - PC update: PC ← `dec_pc_in` if `dec_pc_we`, else PC+1 modulo 2^PC_W (63 wraps to 0).
    - `instr_count` increments and saturates at 16'hFFFF.
    - Next state: HALT if PC was `PC_LAST` and `dec_pc_we` = 0; otherwise FETCH.
  - HALT: on `start` high, clear PC to 0 and go to FETCH. `instr_count` is not cleared.
- JNZ depends on `zf` from the most recent flag-setting EXEC. JMP and JNZ never modify `zf`.
- Because `ir` is stable from DECODE through WB, the decoder outputs are stable through those states.
- `reg_we` and `dmem_req` are never high outside WB and MEM respectively.
- Reset values: state IDLE; PC 0; `ir` 16'h0000; `zf` 0; `instr_count` 0; every strobe, request, `busy` and `done` 0.
- Asserting `rst` mid-operation drops `imem_req`/`dmem_req` asynchronously. Any pending access is abandoned, and the memories must tolerate a withdrawn request.

## Timing
- Minimum latency per instruction, with ack in the same cycle as the request:
  - 4 cycles without a memory access (FETCH, DECODE, EXEC, WB).
  - 5 cycles with a memory access.
- Each wait cycle on `imem_ack` or `dmem_ack` adds one cycle. There is no timeout.
- Requests are level signals held until ack. An ack while no request is outstanding is ignored.
- `ir` updates on the clock edge that samples `imem_ack`.
- The PC update and the `reg_we` cycle coincide, so the register file writes on the WB edge.
- The PC update becomes visible on `imem_addr` in the next FETCH.
- `start` held high in HALT restarts immediately, so the program loops.

## Structure
- Shared package/header:
  - The 4-bit opcode constants (SUB … CHECK_MAP, JMP, JNZ), already used by the decoder.
  - The state encoding localparams.
- Sub-module: the sequencer is a single module.
- Top-level wrapper (`cpu_core`) instantiates `cpu_sequencer`, the decoder, the ALU and the register file.

## Test plan
- Reset, then `start` with a 1-cycle-ack memory holding LI at address 0 → `imem_addr` = 0, `ir` loaded, `reg_we` high for 1 cycle 3 cycles after the fetch, next fetch at address 1, `instr_count` = 1.
- `imem_ack` delayed 3 cycles → `imem_req`/`imem_addr` held stable, `ir` unchanged until the ack edge, total 7 cycles.
- LOAD with `dmem_ack` after 2 cycles → `dmem_req` high 2 cycles with `dmem_we` = 0, then `reg_we` pulses; STORE → `dmem_we` = 1 and no `reg_we`.
- COMPARE with `alu_zf` = 1, then JNZ with target 6'd10 → `zf` = 1 and the next fetch is at 10. Repeat with `alu_zf` = 0 → the next fetch is at PC+1.
- With `PC_LAST` = 3 and straight-line code → `done` asserts after the 4th instruction and `instr_count` = 4. A JMP at PC 3 continues instead of halting. At PC 63 with `PC_LAST` = 62, PC wraps to 0.
- `rst` asserted mid-MEM → `dmem_req` drops the same cycle, all outputs return to reset values, and `start` resumes from PC 0.
